// File: rtl/chan_reduce_unit.sv
// Operand bank with a sequential fold engine: CHANNELS registers folded one per cycle by mode (wrap/sat sum, max, xor).
// Latency CHANNELS+1 edges from start to the done pulse; no backpressure, loads and start are ignored while busy.
module chan_reduce_unit #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    ld_data,
  input  logic [CHANNELS-1:0] ld_sel,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                ovf
);

  localparam int IW = $clog2(CHANNELS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ch [CHANNELS];
  logic [WIDTH-1:0] acc, acc_nxt, cur;
  logic             acc_ovf, ovf_nxt;
  logic [IW-1:0]    idx;
  logic [1:0]       mode_q;
  logic [WIDTH:0]   sum;
  logic             last;

  always_comb begin
    cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == IW'(i)) cur = ch[i];
    end
    sum     = {1'b0, acc} + {1'b0, cur};
    acc_nxt = acc;
    ovf_nxt = 1'b0;
    // Saturation stays sticky without extra state: once acc is all-ones any add carries or adds zero.
    case (mode_q)
      2'b00: begin
        acc_nxt = sum[WIDTH-1:0];
        ovf_nxt = acc_ovf | sum[WIDTH];
      end
      2'b01: begin
        acc_nxt = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        ovf_nxt = acc_ovf | sum[WIDTH];
      end
      2'b10:   acc_nxt = (cur > acc) ? cur : acc;
      default: acc_nxt = acc ^ cur;
    endcase
    last = (idx == LAST_IDX);

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      default: if (last)  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      acc_ovf <= 1'b0;
      idx     <= '0;
      mode_q  <= 2'b00;
      result  <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) ch[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (ld_sel[i]) ch[i] <= ld_data;
        end
        if (start) begin
          mode_q  <= mode;
          acc     <= '0;
          acc_ovf <= 1'b0;
          idx     <= '0;
        end
      end else begin
        acc     <= acc_nxt;
        acc_ovf <= ovf_nxt;
        idx     <= idx + IW'(1);
        if (last) begin
          result <= acc_nxt;
          ovf    <= ovf_nxt;
          done   <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_chan_reduce_unit.sv
// Directed bench for chan_reduce_unit: cycle-level reference model on the 4x4 instance plus literal checks,
// and a WIDTH=8/CHANNELS=6 instance exercised for saturation and latency.
module tb_chan_reduce_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ld_data;
  logic [3:0] ld_sel;
  logic       start;
  logic [1:0] mode;
  logic       busy, done, ovf;
  logic [3:0] result;

  logic [7:0] v_ld_data;
  logic [5:0] v_ld_sel;
  logic       v_start;
  logic [1:0] v_mode;
  logic       v_busy, v_done, v_ovf;
  logic [7:0] v_result;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  chan_reduce_unit #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_data(ld_data), .ld_sel(ld_sel), .start(start), .mode(mode),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  chan_reduce_unit #(.WIDTH(8), .CHANNELS(6)) dut_v (
    .clk(clk), .rst_n(rst_n), .ld_data(v_ld_data), .ld_sel(v_ld_sel), .start(v_start), .mode(v_mode),
    .busy(v_busy), .done(v_done), .result(v_result), .ovf(v_ovf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference reduction straight from the arithmetic rules: partial sums only grow,
  // so a carry at any step is equivalent to the full sum reaching 2^WIDTH.
  function automatic logic [4:0] model_reduce(input logic [1:0] md, input logic [3:0] c [4]);
    int total = 0;
    int mx = 0;
    int x = 0;
    for (int i = 0; i < 4; i++) begin
      total += int'(c[i]);
      if (int'(c[i]) > mx) mx = int'(c[i]);
      x = x ^ int'(c[i]);
    end
    case (md)
      2'b00:   return {total >= 16, 4'(total % 16)};
      2'b01:   return (total >= 16) ? 5'b1_1111 : {1'b0, 4'(total)};
      2'b10:   return {1'b0, 4'(mx)};
      default: return {1'b0, 4'(x)};
    endcase
  endfunction

  logic [3:0] m_ch [4];
  int         cyc = 0;
  int         m_busy_until = 0;
  int         m_done_edge = 0;
  bit         m_pending = 0;
  logic [3:0] m_pres = '0;
  bit         m_povf = 0;
  logic [3:0] exp_result = '0;
  bit         exp_ovf = 0, exp_done = 0, exp_busy = 0;
  bit         model_live = 0;

  // Edge-indexed model: a start accepted at edge k finishes at edge k+4 and the
  // unit accepts new work again from edge k+5.
  always @(posedge clk) begin : mdl
    logic [3:0] nch [4];
    logic [4:0] r;
    int bu;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_ch[i] <= '0;
      m_pending    <= 0;
      m_busy_until <= cyc + 1;
      exp_result   <= '0;
      exp_ovf      <= 0;
      exp_done     <= 0;
      exp_busy     <= 0;
      model_live   <= 1;
    end else begin
      nch = m_ch;
      bu  = m_busy_until;
      if (m_pending && cyc == m_done_edge) begin
        exp_result <= m_pres;
        exp_ovf    <= m_povf;
        exp_done   <= 1;
        m_pending  <= 0;
      end else begin
        exp_done <= 0;
      end
      if (cyc >= m_busy_until) begin
        for (int i = 0; i < 4; i++) if (ld_sel[i]) nch[i] = ld_data;
        m_ch <= nch;
        if (start) begin
          r = model_reduce(mode, nch);
          m_pres       <= r[3:0];
          m_povf       <= r[4];
          m_pending    <= 1;
          m_done_edge  <= cyc + 4;
          bu = cyc + 5;
          m_busy_until <= bu;
        end
      end
      exp_busy <= (cyc + 1 < bu);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("model busy",   int'(busy),   int'(exp_busy));
      chk("model done",   int'(done),   int'(exp_done));
      chk("model result", int'(result), int'(exp_result));
      chk("model ovf",    int'(ovf),    int'(exp_ovf));
    end
  end

  task automatic load(input logic [3:0] sel, input logic [3:0] d);
    ld_sel  = sel;
    ld_data = d;
    @(negedge clk);
    ld_sel = '0;
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    load(4'b0001, a);
    load(4'b0010, b);
    load(4'b0100, c);
    load(4'b1000, d);
  endtask

  task automatic reduce(input logic [1:0] m, input int er, input int eo, input string nm);
    int lat, nb;
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    lat = 1;
    nb  = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    chk({nm, " done seen"}, int'(done), 1);
    chk({nm, " latency"}, lat, 5);
    chk({nm, " busy cycles"}, nb, 4);
    chk({nm, " result"}, int'(result), er);
    chk({nm, " ovf"}, int'(ovf), eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gap, npulse;
    int vals [6];
    vals = '{200, 50, 10, 1, 1, 1};
    v_ld_data = '0; v_ld_sel = '0; v_start = 1'b0; v_mode = 2'b00;
    rst_n = 1'b0;
    repeat (2) begin
      ld_data = 4'($urandom);
      ld_sel  = 4'($urandom);
      start   = 1'($urandom);
      mode    = 2'($urandom);
      @(negedge clk);
    end
    ld_sel = '0;
    start  = 1'b0;
    mode   = 2'b00;
    chk("reset result", int'(result), 0);
    chk("reset ovf",    int'(ovf),    0);
    chk("reset busy",   int'(busy),   0);
    chk("reset done",   int'(done),   0);
    rst_n = 1'b1;
    @(negedge clk);

    reduce(2'b00, 0, 0, "post-reset sum");
    load4(4'd3, 4'd5, 4'd2, 4'd4);
    reduce(2'b00, 14, 0, "wrap sum");
    load(4'b1111, 4'd9);
    reduce(2'b00, 4, 1, "wrap overflow");
    reduce(2'b01, 15, 1, "sat overflow");
    load4(4'd3, 4'd12, 4'd7, 4'd1);
    reduce(2'b10, 12, 0, "max");
    load4(4'd3, 4'd5, 4'd2, 4'd4);
    reduce(2'b11, 0, 0, "xor");

    // start and load pulsed in the middle of a run must both be dropped
    mode  = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    ld_sel  = 4'b0001;
    ld_data = 4'd15;
    @(negedge clk);
    start  = 1'b0;
    ld_sel = '0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("mid-run result", int'(result), 14);
    reduce(2'b00, 14, 0, "frozen channels");

    // start held through the done cycle
    mode  = 2'b00;
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    chk("b2b first done", int'(done), 1);
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b done spacing", gap, 5);
    chk("b2b result", int'(result), 14);
    @(negedge clk);

    // reset during the second RUN cycle aborts without a done pulse
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy",   int'(busy),   0);
    chk("abort done",   int'(done),   0);
    chk("abort result", int'(result), 0);
    rst_n = 1'b1;
    npulse = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("abort no done", npulse, 0);

    // wide variant: 200+50+10+1+1+1 saturates at 255
    for (int i = 0; i < 6; i++) begin
      v_ld_sel  = 6'(1 << i);
      v_ld_data = 8'(vals[i]);
      @(negedge clk);
    end
    v_ld_sel = '0;
    v_mode   = 2'b01;
    v_start  = 1'b1;
    @(negedge clk);
    v_start = 1'b0;
    v_mode  = 2'b00;
    lat = 1;
    while (!v_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("variant done seen", int'(v_done), 1);
    chk("variant latency", lat, 7);
    chk("variant result", int'(v_result), 255);
    chk("variant ovf", int'(v_ovf), 1);
    @(negedge clk);
    chk("variant done pulse width", int'(v_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/chan_reduce_unit.md
# chan_reduce_unit

Parametrised operand bank plus sequential reduction engine, the next generation of the four-register input stage. `CHANNELS` operand registers of `WIDTH` bits are loaded from a shared data bus by per-channel strobes. On `start`, a small state machine folds all channels, one per cycle, using the operation selected by `mode`. It then presents a registered result with a one-cycle `done` pulse. It sits between the switch/strobe input decode and the output display logic of the top level.

## Interface
- `WIDTH`, 4, bit width of each operand register, the accumulator and `result` (>=1)
- `CHANNELS`, 4, number of operand registers (>=1); index counter width is clog2(CHANNELS+1)
- `clk` input 1 clock; all state updates on rising edge
- `rst_n` input 1 reset, synchronous, active-low
- `ld_data` input WIDTH value written to selected channels
- `ld_sel` input CHANNELS per-channel load strobe; any combination may be high
- `start` input 1 request a reduction; sampled only in IDLE
- `mode` input 2 operation: 00 wrapping sum, 01 saturating sum, 10 unsigned max, 11 xor
- `busy` output 1 high while a reduction is in progress
- `done` output 1 one-cycle pulse when `result`/`ovf` update
- `result` output WIDTH last completed reduction value
- `ovf` output 1 overflow flag of last completed reduction

## Operation
- **Reset (`rst_n`=0 at an edge):**
  - All channel registers, accumulator, index, `result` and `ovf` clear to 0.
  - `busy`=0, `done`=0, state returns to IDLE.
  - A reduction in progress is aborted with no `done` pulse.
- **Loads:**
  - In IDLE, at each edge, `ch[i] <= ld_data` for every `i` with `ld_sel[i]`=1.
  - Multiple strobes load the same value into all selected channels.
  - While `busy`=1, `ld_sel` is ignored and channels are frozen. The operands seen by a reduction are therefore exactly the channel values at the start edge.
- **State machine:** IDLE, RUN.
  - **IDLE + `start`=1:**
    - `mode` latched into an internal register.
    - Accumulator set to 0, which is the identity for all four modes.
    - Overflow accumulator cleared, index set to 0, state moves to RUN.
  - **IDLE + `start`=0:** remain in IDLE.
  - **RUN:** each edge combines `ch[index]` into the accumulator and increments `index`.
  - **RUN, `index`=CHANNELS-1:** the final combine is written straight to `result`/`ovf`, `done` is set to 1 for one cycle, and state returns to IDLE.
  - `start` is ignored in RUN. Changes to `mode` after the start edge are ignored.
- **Arithmetic (unsigned, WIDTH bits):**
  - **00:** acc = (acc + ch) mod 2^WIDTH. `ovf` is set if any step produces a carry-out.
  - **01:** if acc + ch >= 2^WIDTH then acc = 2^WIDTH-1 and `ovf` is set; otherwise acc = acc + ch. Saturation is sticky: later adds stay at the maximum.
  - **10:** acc = max(acc, ch). `ovf`=0.
  - **11:** acc = acc ^ ch. `ovf`=0.
- `result` and `ovf` hold their value until the next completion or reset.

## Timing
- `start` sampled at edge E0. Combines happen at edges E1..E_CHANNELS.
- `result`, `ovf` and `done`=1 are valid in the cycle after E_CHANNELS. Latency from the start edge is CHANNELS+1 edges.
- `busy`=1 in the cycles after E0..E_(CHANNELS-1). `busy`=0 in the `done` cycle.
- A `start` during the `done` cycle is accepted, because the state is already IDLE. This gives back-to-back reductions, one every CHANNELS+1 cycles.
- A load and a `start` at the same IDLE edge: the load takes effect first. The reduction uses the newly loaded values, because combining begins at E1.
- CHANNELS=1: single combine at E1, `done` after E1.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
Defaults WIDTH=4, CHANNELS=4 unless stated.
- **Reset:** hold `rst_n`=0 for 2 cycles with random inputs -> `result`=0, `ovf`=0, `busy`=0, `done`=0. A subsequent mode-00 start with no loads gives `result`=0.
- **Wrapping sum:** load 3,5,2,4 with one-hot `ld_sel`, then `start` with mode 00 -> `busy` high for 4 cycles, `done` pulses exactly once 5 edges after the start edge, `result`=14, `ovf`=0.
- **Overflow:** `ld_sel`=1111 with `ld_data`=9 (all channels =9).
  - Mode 00 -> `result`=4, `ovf`=1.
  - Mode 01 -> `result`=15, `ovf`=1.
- **Max and xor:**
  - Load 3,12,7,1, mode 10 -> `result`=12, `ovf`=0.
  - Load 3,5,2,4, mode 11 -> `result`=0.
- **Handshake:**
  - Pulse `start` and `ld_sel`=0001 with `ld_data`=15 mid-RUN -> both ignored, `result` unchanged from the expected value.
  - `start` held high through the `done` cycle -> second reduction begins immediately, with `done` pulses 5 cycles apart.
- **Abort and variant:**
  - Assert `rst_n`=0 on the second RUN cycle -> `busy`=0 next cycle, `done` never pulses, `result`=0.
  - Repeat the sum test with WIDTH=8, CHANNELS=6, loads 200,50,10,1,1,1, mode 01 -> `result`=255, `ovf`=1, latency 7 edges.
